ines_loader: RTL and testbench
==============================

INES_LOADER -- requirements
Module: ines_loader

Interface
REQ-001 PRG_BASE, 22'h000000, SDRAM byte address of the first PRG byte.
REQ-002 CHR_BASE, 22'h200000, SDRAM byte address of the first CHR byte.
REQ-003 FIFO_DEPTH, 4, number of byte entries in the input buffer.
REQ-004 clk  in  1  system clock.
REQ-005 resetn  in  1  reset, synchronous, active-low.
REQ-006 rom_loading  in  1  rising edge = load start, falling edge = load end.
REQ-007 rom_do  in  8  ROM byte stream.
REQ-008 rom_do_valid  in  1  byte strobe; one byte per 0->1 edge.
REQ-009 mem_req  out  1  SDRAM byte-write request, level.
REQ-010 mem_addr  out  22  write address.
REQ-011 mem_data  out  8  write data.
REQ-012 mem_ack  in  1  one-cycle write-complete pulse.
REQ-013 prg_units  out  8  iNES byte 4 (16 KB units).
REQ-014 chr_units  out  8  iNES byte 5 (8 KB units).
REQ-015 mapper  out  8  {byte7[7:4], byte6[7:4]}.
REQ-016 mirroring  out  1  byte6[0].
REQ-017 battery  out  1  byte6[1].
REQ-018 busy, done, error  out  1 each  status flags.
REQ-019 err_code  out  3  1 bad magic, 2 PRG size, 3 truncated, 4 overflow.

Function
REQ-020 rom_do_valid and rom_loading SHALL be edge-detected against their registered previous values; a byte is captured on the clk edge at which rom_do_valid is first seen high.
REQ-021 Bytes captured while rom_loading is low SHALL be ignored.
REQ-022 A rom_loading rising edge from any state SHALL clear all counters, the FIFO, the header outputs, done, error and err_code, and enter HEADER with busy=1.
REQ-023 States: IDLE, HEADER, TRAINER, PRG, CHR, DRAIN, DONE, ERROR.
REQ-024 HEADER SHALL consume 16 bytes without writing to memory. Bytes 0-3 SHALL equal 4E 45 53 1A, else ERROR with code 1 after byte 3.
REQ-025 After byte 15: prg_units==0 or prg_units>128 SHALL go to ERROR with code 2. Otherwise the next state SHALL be TRAINER if byte6[2]=1, else PRG.
REQ-026 TRAINER SHALL discard exactly 512 bytes, then enter PRG.
REQ-027 PRG SHALL write prg_units*16384 bytes to PRG_BASE+n; CHR SHALL write chr_units*8192 bytes to CHR_BASE+n. The offset n is 22-bit and starts at 0 in each region.
REQ-028 When chr_units==0, PRG SHALL proceed directly to DRAIN.
REQ-029 Bytes after the last CHR byte SHALL be discarded without error.
REQ-030 PRG/CHR bytes SHALL pass through a FIFO_DEPTH FIFO. A capture while the FIFO is full SHALL go to ERROR with code 4.
REQ-031 Handshake: when the FIFO is non-empty and mem_req=0, mem_req SHALL rise on the next cycle with mem_addr and mem_data stable. The request SHALL be held until the cycle mem_ack=1; the FIFO SHALL pop on the ack and mem_req SHALL drop for at least one cycle.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 DRAIN SHALL wait for an empty FIFO and mem_req=0, then enter DONE: done=1, busy=0.
REQ-034 A rom_loading falling edge in HEADER, TRAINER, PRG or CHR SHALL go to ERROR with code 3. In DRAIN, DONE or ERROR it SHALL have no effect.
REQ-035 ERROR SHALL set error=1 and busy=0, flush the FIFO, and drop mem_req immediately, abandoning any outstanding write. Only the first error code SHALL be recorded.
REQ-036 A simultaneous rising edge of rom_loading and byte capture SHALL apply the restart (REQ-022) first; that byte is treated as header byte 0.

Reset
REQ-037 While resetn=0 the block SHALL enter IDLE with all outputs 0, the FIFO empty and the edge-detect registers cleared. This holds mid-transfer: mem_req SHALL be 0 on the first clk edge with resetn low.

Verification
REQ-038 Header 4E 45 53 1A 02 01 01 00, 32768 PRG bytes, 8192 CHR bytes, ack 2 cycles after each req -> 40960 writes at 0x000000-0x007FFF and 0x200000-0x201FFF; done=1, mapper=0, mirroring=1.
REQ-039 Header byte 0 = 0x4D -> error=1, err_code=1, no mem_req ever asserted.
REQ-040 byte6=0x14, prg_units=1, chr_units=0 -> 512 trainer bytes discarded; first write is at 0x000000 with trainer byte 512's successor; done after 16384 writes; mapper=0x01.
REQ-041 mem_ack withheld for 20 cycles while bytes arrive every 4 cycles -> error=1, err_code=4, mem_req=0.
REQ-042 rom_loading dropped after 1000 PRG bytes -> err_code=3. A following rom_loading rise clears error and restarts in HEADER.
REQ-043 resetn pulsed low while mem_req=1 -> mem_req=0 and all outputs 0 on the next edge; the state returns to IDLE.

Source files
------------

// File: rtl/ines_loader.sv
// rtl/ines_loader.sv - iNES ROM image loader streaming PRG/CHR payload into SDRAM
// Purpose: parses the 16-byte iNES header from a byte stream, skips an
//   optional 512-byte trainer, then writes PRG followed by CHR bytes to SDRAM
//   through a small FIFO using a level req / pulse ack write handshake.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   i_rom_loading         load window: rise restarts the load, fall ends it
//   i_rom_do              ROM byte stream
//   i_rom_do_valid        byte strobe, one byte per 0->1 edge
//   o_mem_req             SDRAM write request, held until i_mem_ack
//   o_mem_addr/o_mem_data write address/data, stable while o_mem_req=1
//   i_mem_ack             one-cycle write-complete pulse
//   o_prg_units           header byte 4 (16 KB units)
//   o_chr_units           header byte 5 (8 KB units)
//   o_mapper              {byte7[7:4], byte6[7:4]}
//   o_mirroring/o_battery header byte 6 bits 0 and 1
//   o_busy/o_done/o_error status flags
//   o_err_code            1 bad magic, 2 PRG size, 3 truncated, 4 overflow
module ines_loader #(
  parameter logic [21:0] PRG_BASE   = 22'h000000,
  parameter logic [21:0] CHR_BASE   = 22'h200000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_rom_loading,
  input  logic [7:0]  i_rom_do,
  input  logic        i_rom_do_valid,
  output logic        o_mem_req,
  output logic [21:0] o_mem_addr,
  output logic [7:0]  o_mem_data,
  input  logic        i_mem_ack,
  output logic [7:0]  o_prg_units,
  output logic [7:0]  o_chr_units,
  output logic [7:0]  o_mapper,
  output logic        o_mirroring,
  output logic        o_battery,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_code
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  w_err_nxt;

  logic        r_loading_d;
  logic        r_valid_d;
  logic [3:0]  r_hdr_cnt;
  logic        r_magic_bad;
  logic        r_trainer;
  logic [21:0] r_byte_cnt;
  logic [7:0]  r_prg_units;
  logic [7:0]  r_chr_units;
  logic [7:0]  r_mapper;
  logic        r_mirroring;
  logic        r_battery;
  logic [2:0]  r_err_code;

  logic [21:0] r_fifo_addr [FIFO_DEPTH];
  logic [7:0]  r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic        r_mem_req;
  logic [21:0] r_mem_addr;
  logic [7:0]  r_mem_data;

  logic        w_load_rise;
  logic        w_load_fall;
  logic        w_cap;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_magic_byte;
  logic        w_byte_bad;
  logic [21:0] w_prg_last;
  logic [21:0] w_chr_last;
  logic [21:0] w_push_addr;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;

  // Edge detection; bytes outside the load window never count as captures.
  assign w_load_rise  = i_rom_loading & ~r_loading_d;
  assign w_load_fall  = ~i_rom_loading & r_loading_d;
  assign w_cap        = i_rom_do_valid & ~r_valid_d & i_rom_loading;

  assign w_fifo_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  always_comb begin
    w_magic_byte = 8'h1A;
    case (r_hdr_cnt[1:0])
      2'd0:    w_magic_byte = 8'h4E;
      2'd1:    w_magic_byte = 8'h45;
      2'd2:    w_magic_byte = 8'h53;
      default: w_magic_byte = 8'h1A;
    endcase
  end
  assign w_byte_bad = (i_rom_do != w_magic_byte);

  // Last byte offsets of each region; prg_units <= 128 keeps this in 22 bits.
  assign w_prg_last  = {r_prg_units, 14'd0} - 22'd1;
  assign w_chr_last  = {1'b0, r_chr_units, 13'd0} - 22'd1;
  assign w_push_addr = ((r_state == S_CHR) ? CHR_BASE : PRG_BASE) + r_byte_cnt;

  assign w_push  = w_cap && !w_fifo_full && ((r_state == S_PRG) || (r_state == S_CHR));
  assign w_pop   = r_mem_req && i_mem_ack;
  // Restart and every cycle spent in (or entering) ERROR discard queued writes.
  assign w_flush = w_load_rise || (w_state_nxt == S_ERROR);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; a load rise overrides everything, including a capture
  // in the same cycle, which then becomes header byte 0.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 3'd0;
    if (w_load_rise) begin
      w_state_nxt = S_HEADER;
    end else begin
      case (r_state)
        S_HEADER: begin
          if (w_load_fall) begin
            w_state_nxt = S_ERROR; w_err_nxt = 3'd3;
          end else if (w_cap) begin
            if (r_hdr_cnt == 4'd3 && (r_magic_bad || w_byte_bad)) begin
              w_state_nxt = S_ERROR; w_err_nxt = 3'd1;
            end else if (r_hdr_cnt == 4'd15) begin
              if (r_prg_units == 8'd0 || r_prg_units > 8'd128) begin
                w_state_nxt = S_ERROR; w_err_nxt = 3'd2;
              end else begin
                w_state_nxt = r_trainer ? S_TRAINER : S_PRG;
              end
            end
          end
        end
        S_TRAINER: begin
          if (w_load_fall) begin
            w_state_nxt = S_ERROR; w_err_nxt = 3'd3;
          end else if (w_cap && r_byte_cnt == 22'd511) begin
            w_state_nxt = S_PRG;
          end
        end
        S_PRG: begin
          if (w_load_fall) begin
            w_state_nxt = S_ERROR; w_err_nxt = 3'd3;
          end else if (w_cap) begin
            if (w_fifo_full) begin
              w_state_nxt = S_ERROR; w_err_nxt = 3'd4;
            end else if (r_byte_cnt == w_prg_last) begin
              w_state_nxt = (r_chr_units == 8'd0) ? S_DRAIN : S_CHR;
            end
          end
        end
        S_CHR: begin
          if (w_load_fall) begin
            w_state_nxt = S_ERROR; w_err_nxt = 3'd3;
          end else if (w_cap) begin
            if (w_fifo_full) begin
              w_state_nxt = S_ERROR; w_err_nxt = 3'd4;
            end else if (r_byte_cnt == w_chr_last) begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_fifo_empty && !r_mem_req) w_state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_error = 1'b0;
    case (r_state)
      S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DRAIN: o_busy = 1'b1;
      S_DONE:  o_done  = 1'b1;
      S_ERROR: o_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_loading_d <= 1'b0;
      r_valid_d   <= 1'b0;
    end else begin
      r_loading_d <= i_rom_loading;
      r_valid_d   <= i_rom_do_valid;
    end
  end

  // Header fields, counters and error code
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hdr_cnt   <= 4'd0;
      r_magic_bad <= 1'b0;
      r_trainer   <= 1'b0;
      r_byte_cnt  <= 22'd0;
      r_prg_units <= 8'd0;
      r_chr_units <= 8'd0;
      r_mapper    <= 8'd0;
      r_mirroring <= 1'b0;
      r_battery   <= 1'b0;
      r_err_code  <= 3'd0;
    end else if (w_load_rise) begin
      r_hdr_cnt   <= w_cap ? 4'd1 : 4'd0;
      r_magic_bad <= w_cap && (i_rom_do != 8'h4E);
      r_trainer   <= 1'b0;
      r_byte_cnt  <= 22'd0;
      r_prg_units <= 8'd0;
      r_chr_units <= 8'd0;
      r_mapper    <= 8'd0;
      r_mirroring <= 1'b0;
      r_battery   <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      if (w_state_nxt == S_ERROR && r_state != S_ERROR) r_err_code <= w_err_nxt;
      if (w_cap) begin
        case (r_state)
          S_HEADER: begin
            r_hdr_cnt <= r_hdr_cnt + 4'd1;
            // Byte 3 is compared directly in the next-state logic.
            if (r_hdr_cnt < 4'd3) r_magic_bad <= r_magic_bad | w_byte_bad;
            case (r_hdr_cnt)
              4'd4: r_prg_units <= i_rom_do;
              4'd5: r_chr_units <= i_rom_do;
              4'd6: begin
                r_mapper[3:0] <= i_rom_do[7:4];
                r_mirroring   <= i_rom_do[0];
                r_battery     <= i_rom_do[1];
                r_trainer     <= i_rom_do[2];
              end
              4'd7: r_mapper[7:4] <= i_rom_do[7:4];
              default: ;
            endcase
          end
          S_TRAINER: r_byte_cnt <= (r_byte_cnt == 22'd511) ? 22'd0 : r_byte_cnt + 22'd1;
          S_PRG: if (w_push) r_byte_cnt <= (r_byte_cnt == w_prg_last) ? 22'd0 : r_byte_cnt + 22'd1;
          S_CHR: if (w_push) r_byte_cnt <= (r_byte_cnt == w_chr_last) ? 22'd0 : r_byte_cnt + 22'd1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_push_addr;
      r_fifo_data[r_wr_ptr] <= i_rom_do;
    end
  end

  // FIFO pointers and write handshake: request from the FIFO head, pop on ack,
  // then a mandatory idle cycle before the next request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 22'd0;
      r_mem_data <= 8'd0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_mem_req <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr  <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_mem_req <= 1'b0;
      end else if (!r_mem_req && !w_fifo_empty) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_fifo_addr[r_rd_ptr];
        r_mem_data <= r_fifo_data[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_data  = r_mem_data;
  assign o_prg_units = r_prg_units;
  assign o_chr_units = r_chr_units;
  assign o_mapper    = r_mapper;
  assign o_mirroring = r_mirroring;
  assign o_battery   = r_battery;
  assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_ines_loader.sv
// tb/tb_ines_loader.sv - directed self-checking bench for ines_loader
module tb_ines_loader;

  localparam logic [21:0] CHR_BASE = 22'h200000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rom_loading = 1'b0;
  logic [7:0]  rom_do = 8'd0;
  logic        rom_do_valid = 1'b0;
  logic        mem_req;
  logic [21:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack = 1'b0;
  logic [7:0]  prg_units;
  logic [7:0]  chr_units;
  logic [7:0]  mapper;
  logic        mirroring;
  logic        battery;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;

  ines_loader dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_rom_loading  (rom_loading),
    .i_rom_do       (rom_do),
    .i_rom_do_valid (rom_do_valid),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .o_mem_data     (mem_data),
    .i_mem_ack      (mem_ack),
    .o_prg_units    (prg_units),
    .o_chr_units    (chr_units),
    .o_mapper       (mapper),
    .o_mirroring    (mirroring),
    .o_battery      (battery),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_err_code     (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // SDRAM model: acks ack_delay cycles into each request and scores every
  // completed write against the expected address/data for its index.
  int          ack_delay = 1;
  bit          ack_en = 1'b1;
  int          req_cycles = 0;
  int          wr_count = 0;
  int          wr_bad = 0;
  int          req_rises = 0;
  int          unstable = 0;
  int          drop_bad = 0;
  int          sb_base = 0;
  int          sb_prg_bytes = 16384;
  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [21:0] prev_addr = 22'd0;
  logic [7:0]  prev_data = 8'd0;

  function automatic logic [7:0] pat(input int i);
    logic [31:0] v;
    v = i;
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  always @(negedge clk) begin
    int idx;
    logic [21:0] ea;
    if (mem_req === 1'b1 && !prev_req) req_rises++;
    if (mem_req === 1'b1 && prev_req && (mem_addr !== prev_addr || mem_data !== prev_data)) unstable++;
    if (prev_ack && mem_req === 1'b1) drop_bad++;
    req_cycles = (mem_req === 1'b1) ? req_cycles + 1 : 0;
    mem_ack = (mem_req === 1'b1) && ack_en && (req_cycles == ack_delay);
    if (mem_ack) begin
      idx = wr_count - sb_base;
      ea  = (idx < sb_prg_bytes) ? 22'(idx) : CHR_BASE + 22'(idx - sb_prg_bytes);
      if (mem_addr !== ea || mem_data !== pat(idx)) wr_bad++;
      wr_count++;
    end
    prev_req  = (mem_req === 1'b1);
    prev_ack  = mem_ack;
    prev_addr = mem_addr;
    prev_data = mem_data;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rom_do = b;
    rom_do_valid = 1'b1;
    @(negedge clk);
    rom_do_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_header(input logic [127:0] hdr, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) send_byte(hdr[127-8*i -: 8], gap);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_data, prg_units, chr_units, mapper, mirroring, battery,
         busy, done, error, err_code} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h data=%h busy=%b done=%b error=%b code=%0d, expected all 0",
               mem_req, mem_addr, mem_data, busy, done, error, err_code);
    end
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(8'h4E, 2);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_bytes: busy=%b expected 0", busy);
    end
    checks++;
    if (req_rises !== 0) begin
      errors++; $display("FAIL idle_no_req: req_rises=%0d expected 0", req_rises);
    end
  endtask

  // Trainer + 1x16 KB PRG + 1x8 KB CHR; load rise coincides with header byte 0.
  task automatic test_full_load;
    logic [127:0] hdr;
    int base;
    int rises0;
    hdr = 128'h4E45531A_01011720_00000000_00000000;
    ack_delay = 1; ack_en = 1'b1;
    base = wr_count; sb_base = wr_count; sb_prg_bytes = 16384;
    rises0 = req_rises;
    rom_loading = 1'b1; rom_do = 8'h4E; rom_do_valid = 1'b1;
    @(negedge clk);
    rom_do_valid = 1'b0;
    @(negedge clk);
    send_header(hdr, 1, 15, 2);
    checks++;
    if ({prg_units, chr_units} !== 16'h0101) begin
      errors++; $display("FAIL full_units: got %h expected 0101", {prg_units, chr_units});
    end
    checks++;
    if ({mapper, mirroring, battery} !== {8'h21, 1'b1, 1'b1}) begin
      errors++; $display("FAIL full_flags: mapper=%h mir=%b bat=%b expected 21 1 1", mapper, mirroring, battery);
    end
    for (int i = 0; i < 512; i++) send_byte(8'hEE, 2);
    checks++;
    if (req_rises - rises0 !== 0 || busy !== 1'b1) begin
      errors++; $display("FAIL trainer_no_write: req_rises=%0d busy=%b expected 0 1", req_rises - rises0, busy);
    end
    for (int i = 0; i < 24576; i++) send_byte(pat(i), 2);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, 2);
    for (int c = 0; c < 100 && done !== 1'b1; c++) @(negedge clk);
    checks++;
    if ({done, busy, error} !== 3'b100) begin
      errors++; $display("FAIL full_done: done=%b busy=%b error=%b expected 1 0 0", done, busy, error);
    end
    checks++;
    if (wr_count - base !== 24576) begin
      errors++; $display("FAIL full_write_count: got %0d expected 24576", wr_count - base);
    end
    checks++;
    if (wr_bad !== 0) begin
      errors++; $display("FAIL full_write_data: %0d bad writes expected 0", wr_bad);
    end
    checks++;
    if (unstable !== 0 || drop_bad !== 0) begin
      errors++; $display("FAIL handshake: unstable=%0d no_drop=%0d expected 0 0", unstable, drop_bad);
    end
    rom_loading = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++; $display("FAIL done_ignores_fall: done=%b error=%b expected 1 0", done, error);
    end
  endtask

  task automatic test_bad_size;
    logic [127:0] hdr;
    for (int k = 0; k < 2; k++) begin
      hdr = 128'h4E45531A_00010000_00000000_00000000;
      hdr[95:88] = (k == 0) ? 8'd0 : 8'd129;
      rom_loading = 1'b1;
      @(negedge clk);
      send_header(hdr, 0, 14, 2);
      checks++;
      if ({busy, error} !== 2'b10) begin
        errors++; $display("FAIL bad_size_pending[%0d]: busy=%b error=%b expected 1 0", k, busy, error);
      end
      send_header(hdr, 15, 15, 2);
      checks++;
      if ({error, err_code} !== {1'b1, 3'd2}) begin
        errors++; $display("FAIL bad_size[%0d]: error=%b code=%0d expected 1 2", k, error, err_code);
      end
      rom_loading = 1'b0;
      @(negedge clk);
      checks++;
      if (err_code !== 3'd2) begin
        errors++; $display("FAIL error_ignores_fall[%0d]: code=%0d expected 2", k, err_code);
      end
    end
  endtask

  task automatic test_overflow;
    int base;
    ack_en = 1'b0;
    base = wr_count;
    rom_loading = 1'b1;
    @(negedge clk);
    send_header(128'h4E45531A_01010000_00000000_00000000, 0, 15, 2);
    for (int i = 0; i < 4; i++) send_byte(pat(i), 4);
    checks++;
    if ({mem_req, error} !== 2'b10) begin
      errors++; $display("FAIL overflow_pending: req=%b error=%b expected 1 0", mem_req, error);
    end
    send_byte(pat(4), 4);
    checks++;
    if ({error, err_code, mem_req, busy} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
      errors++; $display("FAIL overflow: error=%b code=%0d req=%b busy=%b expected 1 4 0 0",
                         error, err_code, mem_req, busy);
    end
    checks++;
    if (wr_count - base !== 0) begin
      errors++; $display("FAIL overflow_no_write: got %0d expected 0", wr_count - base);
    end
    rom_loading = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_truncate_restart;
    int base;
    int rises0;
    ack_delay = 2; ack_en = 1'b1;
    base = wr_count; sb_base = wr_count; sb_prg_bytes = 32768;
    rom_loading = 1'b1;
    @(negedge clk);
    send_header(128'h4E45531A_02010100_00000000_00000000, 0, 15, 2);
    checks++;
    if ({prg_units, chr_units, mapper, mirroring, battery} !== {8'h02, 8'h01, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL trunc_header: prg=%h chr=%h mapper=%h mir=%b bat=%b expected 02 01 00 1 0",
                         prg_units, chr_units, mapper, mirroring, battery);
    end
    for (int i = 0; i < 1000; i++) send_byte(pat(i), 4);
    repeat (10) @(negedge clk);
    checks++;
    if (wr_count - base !== 1000 || wr_bad !== 0) begin
      errors++; $display("FAIL trunc_writes: count=%0d bad=%0d expected 1000 0", wr_count - base, wr_bad);
    end
    rom_loading = 1'b0;
    @(negedge clk);
    checks++;
    if ({error, err_code, mem_req} !== {1'b1, 3'd3, 1'b0}) begin
      errors++; $display("FAIL truncated: error=%b code=%0d req=%b expected 1 3 0", error, err_code, mem_req);
    end
    rises0 = req_rises;
    rom_loading = 1'b1;
    @(negedge clk);
    checks++;
    if ({error, err_code, busy, prg_units} !== {1'b0, 3'd0, 1'b1, 8'h00}) begin
      errors++; $display("FAIL restart_clears: error=%b code=%0d busy=%b prg=%h expected 0 0 1 00",
                         error, err_code, busy, prg_units);
    end
    send_header(128'h4D45531A_01010000_00000000_00000000, 0, 3, 2);
    checks++;
    if ({error, err_code} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL bad_magic: error=%b code=%0d expected 1 1", error, err_code);
    end
    send_header(128'h4D45531A_01010000_00000000_00000000, 4, 15, 2);
    for (int i = 0; i < 4; i++) send_byte(pat(i), 2);
    checks++;
    if (err_code !== 3'd1 || req_rises - rises0 !== 0) begin
      errors++; $display("FAIL bad_magic_sticky: code=%0d req_rises=%0d expected 1 0", err_code, req_rises - rises0);
    end
    rom_loading = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_transfer;
    ack_en = 1'b0;
    rom_loading = 1'b1;
    @(negedge clk);
    send_header(128'h4E45531A_01000000_00000000_00000000, 0, 15, 2);
    send_byte(pat(0), 2);
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_req_pending: req=%b expected 1", mem_req);
    end
    resetn = 1'b0;
    rom_loading = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, mem_data, prg_units, chr_units, mapper, mirroring, battery,
         busy, done, error, err_code} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: req=%b prg=%h busy=%b expected all 0", mem_req, prg_units, busy);
    end
    resetn = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, mem_req} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_idle: busy=%b done=%b error=%b req=%b expected 0 0 0 0",
                         busy, done, error, mem_req);
    end
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_bad_size;
    test_overflow;
    test_truncate_restart;
    test_reset_mid_transfer;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
